// File: rtl/mips16_run_ctrl.sv
// Run controller for the 16-bit single-cycle MIPS core: streams a program into
// instruction memory, then sequences the core through run, step, pause and halt.
module mips16_run_ctrl #(
  parameter  int IMEM_WORDS = 256,
  parameter  int CYC_W      = 24,
  localparam int AW         = $clog2(IMEM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  // Load port: a beat transfers when load_valid && load_ready are both high on
  // a rising edge; load_ready is high only while idle.
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [15:0]      load_data,
  input  logic             load_last,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             reload,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  input  logic [CYC_W-1:0] cycle_limit,
  input  logic [15:0]      pc,
  output logic             core_rst,
  output logic             core_en,
  output logic             imem_we,
  output logic [AW-1:0]    imem_waddr,
  output logic [15:0]      imem_wdata,
  output logic [2:0]       state,
  output logic [2:0]       halt_cause,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSE  = 3'd3,
    S_STEP   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t          st;
  logic [AW-1:0]   load_ptr;
  logic [15:0]     prev_pc;
  logic            last_en;
  logic            bp_skip;
  logic            fire_ext;
  logic            fire_bp;
  logic            fire_loop;
  logic            fire_lim;
  logic            run_stop;
  logic            load_fire;

  always_comb begin
    fire_ext  = halt_req;
    fire_bp   = bp_en && (pc == bp_addr) && !bp_skip;
    fire_loop = last_en && (pc == prev_pc);
    fire_lim  = (cycle_limit != '0) && (cycle_count == cycle_limit);
    run_stop  = fire_ext || fire_bp || fire_loop || fire_lim;
    load_fire = (st == S_IDLE) && load_valid;
  end

  // Halt checks gate the enable in the same cycle they fire.
  assign core_en    = ((st == S_RUN) && !run_stop) || (st == S_STEP);
  assign core_rst   = (st == S_IDLE) || (st == S_READY);
  assign load_ready = (st == S_IDLE);
  assign imem_we    = load_fire;
  assign imem_waddr = load_ptr;
  assign imem_wdata = load_data;
  assign state      = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_IDLE;
      load_ptr    <= '0;
      prev_pc     <= '0;
      last_en     <= 1'b0;
      bp_skip     <= 1'b0;
      halt_cause  <= 3'd0;
      cycle_count <= '0;
    end else begin
      // last_en drops on any idle cycle so a pause never looks like a self-loop.
      if (core_en) begin
        prev_pc <= pc;
        last_en <= 1'b1;
        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      end else begin
        last_en <= 1'b0;
      end

      case (st)
        S_IDLE: begin
          if (load_fire) begin
            if (load_last || (load_ptr == AW'(IMEM_WORDS - 1))) begin
              st       <= S_READY;
              load_ptr <= '0;
            end else begin
              load_ptr <= load_ptr + 1'b1;
            end
          end
        end
        S_READY: begin
          if (reload) begin
            st <= S_IDLE;
          end else if (start) begin
            cycle_count <= '0;
            halt_cause  <= 3'd0;
            bp_skip     <= 1'b0;
            st          <= step_mode ? S_PAUSE : S_RUN;
          end
        end
        S_RUN: begin
          if (fire_ext) begin
            st <= S_HALTED; halt_cause <= 3'd3;
          end else if (fire_bp) begin
            st <= S_PAUSE;  halt_cause <= 3'd4;
          end else if (fire_loop) begin
            st <= S_HALTED; halt_cause <= 3'd1;
          end else if (fire_lim) begin
            st <= S_HALTED; halt_cause <= 3'd2;
          end else begin
            bp_skip <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (reload) begin
            st <= S_IDLE;
          end else if (halt_req) begin
            st <= S_HALTED; halt_cause <= 3'd3;
          end else if (start && !step_mode) begin
            st      <= S_RUN;
            bp_skip <= 1'b1;
          end else if (step) begin
            st <= S_STEP;
          end
        end
        S_STEP: st <= S_PAUSE;
        S_HALTED: begin
          if (reload)     st <= S_IDLE;
          else if (start) st <= S_READY;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips16_run_ctrl.sv
// Directed bench for mips16_run_ctrl with a tiny PC-advancing core stand-in.
module tb_mips16_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_last, start, step_mode, step, reload, halt_req, bp_en;
  logic [15:0] load_data, bp_addr;
  logic [23:0] cycle_limit;
  logic        load_ready, core_rst, core_en, imem_we;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic [2:0]  state, halt_cause;
  logic [23:0] cycle_count;

  logic        load_valid2;
  logic [15:0] load_data2;
  logic        load_ready2, core_rst2, core_en2, imem_we2;
  logic [1:0]  imem_waddr2;
  logic [15:0] imem_wdata2;
  logic [2:0]  state2, halt_cause2;
  logic [23:0] cycle_count2;

  logic [15:0] core_pc;
  logic [15:0] loop_pc;
  int          en_cnt;
  int          vec;
  int          miss;

  always #5 clk = ~clk;

  mips16_run_ctrl dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .step_mode(step_mode),
    .step(step), .reload(reload), .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .cycle_limit(cycle_limit), .pc(core_pc), .core_rst(core_rst), .core_en(core_en),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .state(state),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  mips16_run_ctrl #(.IMEM_WORDS(4), .CYC_W(24)) dut_small (
    .clk(clk), .reset(reset), .load_valid(load_valid2), .load_ready(load_ready2),
    .load_data(load_data2), .load_last(1'b0), .start(1'b0), .step_mode(1'b0),
    .step(1'b0), .reload(1'b0), .halt_req(1'b0), .bp_en(1'b0), .bp_addr(16'h0),
    .cycle_limit(24'd0), .pc(16'h0), .core_rst(core_rst2), .core_en(core_en2),
    .imem_we(imem_we2), .imem_waddr(imem_waddr2), .imem_wdata(imem_wdata2), .state(state2),
    .halt_cause(halt_cause2), .cycle_count(cycle_count2)
  );

  // Core stand-in: PC advances by 2 per enabled cycle and sticks at loop_pc.
  always @(posedge clk) begin
    if (core_rst) core_pc <= 16'h0;
    else if (core_en) core_pc <= (core_pc == loop_pc) ? core_pc : core_pc + 16'd2;
  end

  always @(posedge clk) en_cnt <= en_cnt + (core_en ? 1 : 0);

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (state === s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_start(input logic sm);
    @(negedge clk); step_mode = sm; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; #1;
    vec++; if (state !== 3'd0) begin miss++; $display("FAIL reset_state: got %0d want 0", state); end
    vec++; if (core_rst !== 1'b1 || core_en !== 1'b0) begin miss++; $display("FAIL reset_core: rst %b en %b want 1 0", core_rst, core_en); end
    vec++; if (load_ready !== 1'b1 || imem_we !== 1'b0 || imem_waddr !== 8'd0) begin miss++; $display("FAIL reset_load: rdy %b we %b addr %0d want 1 0 0", load_ready, imem_we, imem_waddr); end
    vec++; if (cycle_count !== 24'd0 || halt_cause !== 3'd0) begin miss++; $display("FAIL reset_cnt: cnt %0d cause %0d want 0 0", cycle_count, halt_cause); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); load_valid2 = 1'b1; load_data2 = 16'hB000 + 16'(i); #1;
      if (i < 4) begin
        vec++; if (imem_we2 !== 1'b1 || imem_waddr2 !== 2'(i) || imem_wdata2 !== 16'hB000 + 16'(i)) begin
          miss++; $display("FAIL ovf_write%0d: we %b addr %0d data %h", i, imem_we2, imem_waddr2, imem_wdata2); end
      end else begin
        vec++; if (imem_we2 !== 1'b0 || load_ready2 !== 1'b0) begin
          miss++; $display("FAIL ovf_ignore%0d: we %b rdy %b want 0 0", i, imem_we2, load_ready2); end
      end
    end
    @(negedge clk); load_valid2 = 1'b0; #1;
    vec++; if (state2 !== 3'd1) begin miss++; $display("FAIL ovf_state: got %0d want 1", state2); end
  endtask

  task automatic test_load_run;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); load_valid = 1'b1; load_data = 16'hA000 + 16'(i); load_last = (i == 3); #1;
      vec++; if (imem_we !== 1'b1 || imem_waddr !== 8'(i) || imem_wdata !== 16'hA000 + 16'(i)) begin
        miss++; $display("FAIL load_beat%0d: we %b addr %0d data %h", i, imem_we, imem_waddr, imem_wdata); end
    end
    @(negedge clk); load_valid = 1'b0; load_last = 1'b0; #1;
    vec++; if (state !== 3'd1 || load_ready !== 1'b0) begin miss++; $display("FAIL load_ready_state: state %0d rdy %b want 1 0", state, load_ready); end
    @(negedge clk); step_mode = 1'b0; start = 1'b1; #1;
    vec++; if (core_rst !== 1'b1) begin miss++; $display("FAIL start_same_cycle_rst: got %b want 1", core_rst); end
    @(negedge clk); start = 1'b0; #1;
    vec++; if (state !== 3'd2 || core_rst !== 1'b0 || core_en !== 1'b1 || cycle_count !== 24'd0) begin
      miss++; $display("FAIL run_entry: state %0d rst %b en %b cnt %0d want 2 0 1 0", state, core_rst, core_en, cycle_count); end
    @(negedge clk); #1;
    vec++; if (cycle_count !== 24'd1) begin miss++; $display("FAIL run_cnt1: got %0d want 1", cycle_count); end
    @(negedge clk); halt_req = 1'b1; #1;
    vec++; if (cycle_count !== 24'd2 || core_pc !== 16'h0004 || core_en !== 1'b0) begin
      miss++; $display("FAIL ext_same_cycle: cnt %0d pc %h en %b want 2 0004 0", cycle_count, core_pc, core_en); end
    @(negedge clk); halt_req = 1'b0; #1;
    vec++; if (state !== 3'd5 || halt_cause !== 3'd3 || cycle_count !== 24'd2) begin
      miss++; $display("FAIL ext_halt: state %0d cause %0d cnt %0d want 5 3 2", state, halt_cause, cycle_count); end
  endtask

  task automatic test_self_loop;
    bit ok;
    pulse_start(1'b0);
    vec++; if (state !== 3'd1 || core_rst !== 1'b1) begin miss++; $display("FAIL rerun_ready: state %0d rst %b want 1 1", state, core_rst); end
    loop_pc = 16'h0006;
    pulse_start(1'b0);
    wait_state(3'd5, 30, ok);
    vec++; if (!ok) begin miss++; $display("FAIL loop_timeout: state %0d want 5", state); end
    // Three straight-line instructions plus the jump itself.
    vec++; if (halt_cause !== 3'd1 || core_pc !== 16'h0006 || cycle_count !== 24'd4) begin
      miss++; $display("FAIL loop_halt: cause %0d pc %h cnt %0d want 1 0006 4", halt_cause, core_pc, cycle_count); end
  endtask

  task automatic test_breakpoint;
    bit ok;
    pulse_start(1'b0);
    loop_pc = 16'h000A; bp_en = 1'b1; bp_addr = 16'h0004;
    pulse_start(1'b0);
    wait_state(3'd3, 30, ok);
    vec++; if (!ok || halt_cause !== 3'd4 || core_pc !== 16'h0004 || cycle_count !== 24'd2) begin
      miss++; $display("FAIL bp_pause: state %0d cause %0d pc %h cnt %0d want 3 4 0004 2", state, halt_cause, core_pc, cycle_count); end
    pulse_start(1'b0);
    vec++; if (state !== 3'd2 || core_en !== 1'b1 || core_pc !== 16'h0004) begin
      miss++; $display("FAIL bp_resume: state %0d en %b pc %h want 2 1 0004", state, core_en, core_pc); end
    wait_state(3'd5, 30, ok);
    vec++; if (!ok || halt_cause !== 3'd1 || core_pc !== 16'h000A || cycle_count !== 24'd6) begin
      miss++; $display("FAIL bp_continue: state %0d cause %0d pc %h cnt %0d want 5 1 000a 6", state, halt_cause, core_pc, cycle_count); end
    bp_en = 1'b0; loop_pc = 16'hFFFF;
  endtask

  task automatic test_step;
    int en0;
    pulse_start(1'b0);
    pulse_start(1'b1);
    vec++; if (state !== 3'd3 || core_rst !== 1'b0 || core_en !== 1'b0) begin
      miss++; $display("FAIL step_pause: state %0d rst %b en %b want 3 0 0", state, core_rst, core_en); end
    en0 = en_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0; #1;
      vec++; if (state !== 3'd4 || core_en !== 1'b1) begin miss++; $display("FAIL step%0d: state %0d en %b want 4 1", i, state, core_en); end
      @(negedge clk); #1;
      vec++; if (state !== 3'd3 || core_en !== 1'b0) begin miss++; $display("FAIL step%0d_back: state %0d en %b want 3 0", i, state, core_en); end
    end
    vec++; if (en_cnt - en0 !== 3 || cycle_count !== 24'd3 || core_pc !== 16'h0006) begin
      miss++; $display("FAIL step_totals: en %0d cnt %0d pc %h want 3 3 0006", en_cnt - en0, cycle_count, core_pc); end
    @(negedge clk); reload = 1'b1; start = 1'b1;
    @(negedge clk); reload = 1'b0; start = 1'b0; #1;
    vec++; if (state !== 3'd0 || core_rst !== 1'b1 || load_ready !== 1'b1) begin
      miss++; $display("FAIL reload_wins: state %0d rst %b rdy %b want 0 1 1", state, core_rst, load_ready); end
  endtask

  task automatic test_limit;
    bit ok;
    int en0;
    @(negedge clk); load_valid = 1'b1; load_last = 1'b1; load_data = 16'h1234; #1;
    vec++; if (imem_we !== 1'b1 || imem_waddr !== 8'd0) begin miss++; $display("FAIL reload_addr: we %b addr %0d want 1 0", imem_we, imem_waddr); end
    @(negedge clk); load_valid = 1'b0; load_last = 1'b0; #1;
    vec++; if (state !== 3'd1) begin miss++; $display("FAIL single_beat_ready: got %0d want 1", state); end
    cycle_limit = 24'd5;
    en0 = en_cnt;
    pulse_start(1'b0);
    wait_state(3'd5, 30, ok);
    vec++; if (!ok || halt_cause !== 3'd2 || cycle_count !== 24'd5 || en_cnt - en0 !== 5) begin
      miss++; $display("FAIL limit_halt: state %0d cause %0d cnt %0d en %0d want 5 2 5 5", state, halt_cause, cycle_count, en_cnt - en0); end
    cycle_limit = 24'd0;
  endtask

  task automatic test_reset_midrun;
    pulse_start(1'b0);
    pulse_start(1'b0);
    @(negedge clk); @(negedge clk); #1;
    vec++; if (state !== 3'd2 || cycle_count !== 24'd2) begin miss++; $display("FAIL pre_reset_run: state %0d cnt %0d want 2 2", state, cycle_count); end
    #1 reset = 1'b1; #1;
    vec++; if (state !== 3'd0 || core_rst !== 1'b1 || core_en !== 1'b0 || cycle_count !== 24'd0) begin
      miss++; $display("FAIL async_reset: state %0d rst %b en %b cnt %0d want 0 1 0 0", state, core_rst, core_en, cycle_count); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    vec = 0; miss = 0; en_cnt = 0;
    load_valid = 1'b0; load_last = 1'b0; load_data = 16'h0; start = 1'b0; step_mode = 1'b0;
    step = 1'b0; reload = 1'b0; halt_req = 1'b0; bp_en = 1'b0; bp_addr = 16'h0;
    cycle_limit = 24'd0; loop_pc = 16'hFFFF; load_valid2 = 1'b0; load_data2 = 16'h0;
    test_reset;
    test_overflow;
    test_load_run;
    test_self_loop;
    test_breakpoint;
    test_step;
    test_limit;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
